// File: rtl/nora_dma_master.sv
// Block COPY/FILL initiator on the NORA slave bus.
// A single FSM issues single-cycle read/write requests and registers every output.
module nora_dma_master #(
  parameter int AW = 16,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_start_i,
  input  logic          cmd_fill_i,
  input  logic [AW-1:0] cmd_src_i,
  input  logic [AW-1:0] cmd_dst_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic [7:0]    cmd_pattern_i,
  input  logic          cmd_abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic [AW-1:0] mst_addr_o,
  output logic [7:0]    mst_datawr_o,
  output logic          mst_datawr_valid_o,
  input  logic [7:0]    mst_datard_i,
  output logic          mst_req_o,
  output logic          mst_rwn_o
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RW, S_WR, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          fill_q, fill_d;
  logic [7:0]    pat_q, pat_d;
  logic          busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic          req_q, req_d, rwn_q, rwn_d, dv_q, dv_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    datawr_q, datawr_d;

  // Bus outputs default to their idle values every cycle; only the cycle
  // that enters RD or WR drives a request.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    req_d     = 1'b0;
    rwn_d     = 1'b1;
    dv_d      = 1'b0;
    addr_d    = '0;
    datawr_d  = 8'h00;

    if (cmd_abort_i && (state_q == S_RD || state_q == S_RW || state_q == S_WR)) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_start_i) begin
            src_d  = cmd_src_i;
            dst_d  = cmd_dst_i;
            cnt_d  = cmd_len_i;
            fill_d = cmd_fill_i;
            pat_d  = cmd_pattern_i;
            busy_d = 1'b1;
            if (cmd_len_i == '0) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end else if (cmd_fill_i) begin
              state_d  = S_WR;
              req_d    = 1'b1;
              rwn_d    = 1'b0;
              dv_d     = 1'b1;
              addr_d   = cmd_dst_i;
              datawr_d = cmd_pattern_i;
            end else begin
              state_d = S_RD;
              req_d   = 1'b1;
              addr_d  = cmd_src_i;
            end
          end
        end
        S_RD: state_d = S_RW;
        S_RW: begin
          // Slave data is valid during RW; it becomes the write data of the next cycle.
          state_d  = S_WR;
          req_d    = 1'b1;
          rwn_d    = 1'b0;
          dv_d     = 1'b1;
          addr_d   = dst_q;
          datawr_d = mst_datard_i;
        end
        S_WR: begin
          if (!fill_q) src_d = src_q + AW'(1);
          dst_d = dst_q + AW'(1);
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_d = S_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (fill_q) begin
            state_d  = S_WR;
            req_d    = 1'b1;
            rwn_d    = 1'b0;
            dv_d     = 1'b1;
            addr_d   = dst_q + AW'(1);
            datawr_d = pat_q;
          end else begin
            state_d = S_RD;
            req_d   = 1'b1;
            addr_d  = src_q + AW'(1);
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      fill_q    <= 1'b0;
      pat_q     <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      req_q     <= 1'b0;
      rwn_q     <= 1'b1;
      dv_q      <= 1'b0;
      addr_q    <= '0;
      datawr_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      req_q     <= req_d;
      rwn_q     <= rwn_d;
      dv_q      <= dv_d;
      addr_q    <= addr_d;
      datawr_q  <= datawr_d;
    end
  end

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign aborted_o          = aborted_q;
  assign mst_req_o          = req_q;
  assign mst_rwn_o          = rwn_q;
  assign mst_datawr_valid_o = dv_q;
  assign mst_addr_o         = addr_q;
  assign mst_datawr_o       = datawr_q;

endmodule

// File: tb/tb_nora_dma_master.sv
// Bench for nora_dma_master: a RAM slave model, a bus scoreboard fed by the
// scenario tasks, and per-scenario timing and memory checks.
module tb_nora_dma_master;

  logic        clk;
  logic        reset;
  logic        cmd_start_i, cmd_fill_i, cmd_abort_i;
  logic [15:0] cmd_src_i, cmd_dst_i, cmd_len_i;
  logic [7:0]  cmd_pattern_i;
  logic        busy_o, done_o, aborted_o;
  logic [15:0] mst_addr_o;
  logic [7:0]  mst_datawr_o, mst_datard_i;
  logic        mst_datawr_valid_o, mst_req_o, mst_rwn_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Entry: {rwn, addr, data}; data is ignored for reads.
  logic [24:0] exp_q[$];
  logic [24:0] mon_exp;
  bit          mon_ok;
  logic [7:0]  mem [0:65535];

  nora_dma_master #(.AW(16), .LW(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_start_i(cmd_start_i), .cmd_fill_i(cmd_fill_i),
    .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i), .cmd_len_i(cmd_len_i),
    .cmd_pattern_i(cmd_pattern_i), .cmd_abort_i(cmd_abort_i),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .mst_addr_o(mst_addr_o), .mst_datawr_o(mst_datawr_o),
    .mst_datawr_valid_o(mst_datawr_valid_o), .mst_datard_i(mst_datard_i),
    .mst_req_o(mst_req_o), .mst_rwn_o(mst_rwn_o)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave: registered read data, single-cycle write.
  always @(posedge clk) begin
    if (mst_req_o && mst_rwn_o) mst_datard_i <= mem[mst_addr_o];
    if (mst_req_o && !mst_rwn_o && mst_datawr_valid_o) mem[mst_addr_o] <= mst_datawr_o;
  end

  // Bus scoreboard
  always @(negedge clk) begin
    checks++;
    if (mst_req_o) begin
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL bus_unexpected got rwn=%b addr=%h data=%h, no request expected",
                 mst_rwn_o, mst_addr_o, mst_datawr_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp[24])
          mon_ok = (mst_rwn_o === 1'b1) && (mst_addr_o === mon_exp[23:8]);
        else
          mon_ok = (mst_rwn_o === 1'b0) && (mst_addr_o === mon_exp[23:8]) &&
                   (mst_datawr_o === mon_exp[7:0]) && (mst_datawr_valid_o === 1'b1);
        if (!mon_ok) begin
          failures++;
          $display("FAIL bus_txn got rwn=%b addr=%h data=%h dv=%b expected rwn=%b addr=%h data=%h",
                   mst_rwn_o, mst_addr_o, mst_datawr_o, mst_datawr_valid_o,
                   mon_exp[24], mon_exp[23:8], mon_exp[7:0]);
        end
      end
    end else if (mst_datawr_valid_o !== 1'b0 || mst_rwn_o !== 1'b1) begin
      failures++;
      $display("FAIL bus_idle got dv=%b rwn=%b expected dv=0 rwn=1", mst_datawr_valid_o, mst_rwn_o);
    end
  end

  // Driver tasks
  task automatic start_job(input logic fill, input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] len, input logic [7:0] pat, output int t0);
    @(posedge clk); #1;
    cmd_start_i = 1'b1; cmd_fill_i = fill; cmd_src_i = src;
    cmd_dst_i = dst; cmd_len_i = len; cmd_pattern_i = pat;
    t0 = cyc;
    @(posedge clk); #1;
    cmd_start_i = 1'b0;
  endtask

  task automatic push_rd(input logic [15:0] a);
    exp_q.push_back({1'b1, a, 8'h00});
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, a, d});
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, aborted_o, mst_req_o, mst_rwn_o, mst_datawr_valid_o, mst_addr_o, mst_datawr_o}
        !== {6'b000010, 16'h0000, 8'h00}) begin
      failures++;
      $display("FAIL reset_values got busy=%b done=%b ab=%b req=%b rwn=%b dv=%b addr=%h wd=%h",
               busy_o, done_o, aborted_o, mst_req_o, mst_rwn_o, mst_datawr_valid_o, mst_addr_o, mst_datawr_o);
    end
    #1 reset = 1'b0;
    cmd_abort_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 cmd_abort_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, aborted_o, mst_req_o} !== 3'b000) begin
      failures++;
      $display("FAIL idle_abort_ignored got busy=%b aborted=%b req=%b expected 000", busy_o, aborted_o, mst_req_o);
    end
  endtask

  task automatic test_copy();
    int t0, rel;
    bit seen;
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      mem[16'h0100 + i] = vals[i];
      mem[16'h0200 + i] = 8'h00;
      push_rd(16'h0100 + 16'(i));
      push_wr(16'h0200 + 16'(i), vals[i]);
    end
    start_job(1'b0, 16'h0100, 16'h0200, 16'd4, 8'h00, t0);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      checks++;
      if (busy_o !== (rel <= 12)) begin
        failures++;
        $display("FAIL copy_busy rel=%0d got %b expected %b", rel, busy_o, rel <= 12);
      end
      if (done_o) begin
        seen = 1;
        checks++;
        if (rel != 13) begin
          failures++;
          $display("FAIL copy_done_time got %0d expected 13", rel);
        end
      end
    end
    if (!seen) begin
      failures++;
      $display("FAIL copy_done_timeout got none expected done at 13");
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h0200 + i] !== vals[i]) begin
        failures++;
        $display("FAIL copy_mem[%0d] got %h expected %h", i, mem[16'h0200 + i], vals[i]);
      end
    end
  endtask

  task automatic test_fill();
    int t0, rel;
    bit seen;
    for (int i = 0; i < 3; i++) push_wr(16'h0010 + 16'(i), 8'hA5);
    start_job(1'b1, 16'h0000, 16'h0010, 16'd3, 8'hA5, t0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      checks++;
      if (mst_req_o !== (rel <= 3)) begin
        failures++;
        $display("FAIL fill_req rel=%0d got %b expected %b", rel, mst_req_o, rel <= 3);
      end
      if (done_o) begin
        seen = 1;
        checks++;
        if (rel != 4) begin
          failures++;
          $display("FAIL fill_done_time got %0d expected 4", rel);
        end
      end
    end
    if (!seen) begin
      failures++;
      $display("FAIL fill_done_timeout got none expected done at 4");
    end
  endtask

  task automatic test_wrap();
    int t0, rel;
    bit seen;
    logic [15:0] sa [3];
    logic [7:0]  v  [3];
    sa = '{16'hFFFE, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      v[i] = 8'($urandom_range(1, 255));
      mem[sa[i]] = v[i];
      push_rd(sa[i]);
      push_wr(16'h7FFF + 16'(i), v[i]);
    end
    start_job(1'b0, 16'hFFFE, 16'h7FFF, 16'd3, 8'h00, t0);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (done_o) begin
        seen = 1;
        checks++;
        if (rel != 10) begin
          failures++;
          $display("FAIL wrap_done_time got %0d expected 10", rel);
        end
      end
    end
    if (!seen) begin
      failures++;
      $display("FAIL wrap_done_timeout got none expected done at 10");
    end
    checks++;
    if (mem[16'h8001] !== v[2]) begin
      failures++;
      $display("FAIL wrap_mem got %h expected %h", mem[16'h8001], v[2]);
    end
  endtask

  task automatic test_len0();
    int t0;
    start_job(1'b0, 16'h1234, 16'h5678, 16'd0, 8'h00, t0);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, mst_req_o} !== 3'b110) begin
      failures++;
      $display("FAIL len0_fin got busy=%b done=%b req=%b expected 110", busy_o, done_o, mst_req_o);
    end
    @(negedge clk);
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      failures++;
      $display("FAIL len0_idle got busy=%b done=%b expected 00", busy_o, done_o);
    end
  endtask

  task automatic test_abort();
    int t0, t1, rel;
    bit seen;
    logic [7:0] v [5];
    for (int i = 0; i < 5; i++) begin
      v[i] = 8'($urandom_range(1, 255));
      mem[16'h0300 + i] = v[i];
      mem[16'h0400 + i] = 8'h00;
    end
    mem[16'h0410] = 8'h00;
    push_rd(16'h0300);
    push_wr(16'h0400, v[0]);
    push_rd(16'h0301);
    start_job(1'b0, 16'h0300, 16'h0400, 16'd5, 8'h00, t0);
    repeat (4) @(posedge clk);
    #1 cmd_abort_i = 1'b1;
    @(posedge clk);
    #1 cmd_abort_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({aborted_o, done_o, busy_o, mst_req_o} !== 4'b1000) begin
      failures++;
      $display("FAIL abort_pulse got ab=%b done=%b busy=%b req=%b expected 1000",
               aborted_o, done_o, busy_o, mst_req_o);
    end
    @(negedge clk);
    checks++;
    if ({aborted_o, done_o} !== 2'b00) begin
      failures++;
      $display("FAIL abort_one_cycle got ab=%b done=%b expected 00", aborted_o, done_o);
    end
    push_rd(16'h0300);
    push_wr(16'h0410, v[0]);
    start_job(1'b0, 16'h0300, 16'h0410, 16'd1, 8'h00, t1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      rel = cyc - t1;
      if (done_o) begin
        seen = 1;
        checks++;
        if (rel != 4) begin
          failures++;
          $display("FAIL restart_done_time got %0d expected 4", rel);
        end
      end
    end
    if (!seen) begin
      failures++;
      $display("FAIL restart_done_timeout got none expected done at 4");
    end
    checks++;
    if (mem[16'h0401] !== 8'h00 || mem[16'h0410] !== v[0]) begin
      failures++;
      $display("FAIL abort_mem got m401=%h m410=%h expected 00 %h", mem[16'h0401], mem[16'h0410], v[0]);
    end
  endtask

  task automatic test_back_to_back();
    int t0, rel;
    bit seen;
    mem[16'h0700] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      mem[16'h0500 + i] = 8'h60 + 8'(i);
      push_rd(16'h0500 + 16'(i));
      push_wr(16'h0600 + 16'(i), 8'h60 + 8'(i));
    end
    start_job(1'b0, 16'h0500, 16'h0600, 16'd3, 8'h00, t0);
    repeat (3) @(posedge clk);
    #1;
    cmd_start_i = 1'b1; cmd_fill_i = 1'b1; cmd_dst_i = 16'h0700;
    cmd_len_i = 16'd9; cmd_pattern_i = 8'hEE;
    @(posedge clk);
    #1 cmd_start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (done_o) begin
        seen = 1;
        checks++;
        if (rel != 10) begin
          failures++;
          $display("FAIL busy_start_done_time got %0d expected 10", rel);
        end
      end
    end
    if (!seen) begin
      failures++;
      $display("FAIL busy_start_timeout got none expected done at 10");
    end
    checks++;
    if (mem[16'h0700] !== 8'h00) begin
      failures++;
      $display("FAIL busy_start_mem got %h expected 00", mem[16'h0700]);
    end
  endtask

  task automatic test_reset_mid();
    int t0, pulses;
    mem[16'h0803] = 8'h00;
    for (int i = 0; i < 3; i++) push_wr(16'h0800 + 16'(i), 8'h5A);
    start_job(1'b1, 16'h0000, 16'h0800, 16'd8, 8'h5A, t0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, aborted_o, mst_req_o, mst_datawr_valid_o, mst_rwn_o} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b ab=%b req=%b dv=%b rwn=%b expected 000001",
               busy_o, done_o, aborted_o, mst_req_o, mst_datawr_valid_o, mst_rwn_o);
    end
    #1 reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_o || aborted_o || busy_o) pulses++;
    end
    checks++;
    if (pulses != 0 || mem[16'h0803] !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_after got pulses=%0d m803=%h expected 0 00", pulses, mem[16'h0803]);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_start_i = 1'b0; cmd_fill_i = 1'b0; cmd_abort_i = 1'b0;
    cmd_src_i = '0; cmd_dst_i = '0; cmd_len_i = '0; cmd_pattern_i = '0;
    mst_datard_i = 8'h00;
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_len0();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
